// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x400 VGA timing constants, sync-polarity encodings
//               and a small helper that sums the four segments of a raster axis.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Sync polarity encodings: the level a sync output takes while asserted
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x400 @ 70 Hz horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // 640x400 @ 70 Hz vertical timing, in lines
  localparam int DEF_V_ACTIVE = 400;
  localparam int DEF_V_FP     = 12;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 35;

  // Default sync polarities for this mode
  localparam bit DEF_HS_POL = SYNC_ACTIVE_LOW;
  localparam bit DEF_VS_POL = SYNC_ACTIVE_HIGH;

  // Total period of one raster axis (active + front porch + sync + back porch)
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Enable-gated shift register of DEPTH stages. Every stage loads
//               RESET_VAL on reset and shifts only when en is high.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the chain one place per enabled cycle; reset flushes every stage
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else if (en) begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Issues undelayed raster
//               coordinates and a pixel request, and returns hsync/vsync/de
//               and gated pixel data delayed by PIPE enabled cycles so they
//               line up with pixel data fetched from an external source.
//               Optional build macro VGA_TEST_PATTERN_EN adds input test_mode,
//               which replaces pix_in with a scrolling checkerboard.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL,
  parameter int COLOR_W  = 3,
  // Legal range 1..8
  parameter int PIPE     = 2,
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               req,
  output logic               line_start,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] pix_in,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] pix_out,
  output logic [15:0]        frame_cnt
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam int             HS_START = H_ACTIVE + H_FP;
  localparam int             HS_END   = HS_START + H_SYNC;
  localparam int             VS_START = V_ACTIVE + V_FP;
  localparam int             VS_END   = VS_START + V_SYNC;

  logic               w_hs_raw;
  logic               w_vs_raw;
  logic [COLOR_W-1:0] w_pix_sel;
  logic [COLOR_W-1:0] r_pix;

  // Raster counters and completed-frame counter; x and y wrap together at end of frame
  always_ff @(posedge clock) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else if (pix_en) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y == Y_LAST) begin
          y         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          y <= y + Y_W'(1);
        end
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  // Undelayed request and start pulses; pulses only exist on enabled cycles
  assign req         = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
  assign line_start  = pix_en && !reset && (x == '0);
  assign frame_start = line_start && (y == '0);

  // Raw sync levels decoded from the undelayed coordinates
  assign w_hs_raw = ((int'(x) >= HS_START) && (int'(x) < HS_END)) ? HS_POL : ~HS_POL;
  assign w_vs_raw = ((int'(y) >= VS_START) && (int'(y) < VS_END)) ? VS_POL : ~VS_POL;

  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE),
    .RESET_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_timing_dly (
    .clock (clock),
    .reset (reset),
    .en    (pix_en),
    .din   ({w_hs_raw, w_vs_raw, req}),
    .dout  ({hsync, vsync, de})
  );

`ifdef VGA_TEST_PATTERN_EN
  // Checkerboard of 16x16 cells that scrolls with the frame count
  logic [4:0] w_xs;
  logic [4:0] w_ys;
  logic       w_pat_raw;
  logic [1:0] w_pat_tap;

  assign w_xs      = 5'(x) + frame_cnt[4:0];
  assign w_ys      = 5'(y) + frame_cnt[6:2];
  assign w_pat_raw = w_xs[4] ^ w_ys[4];

  // Align {test_mode, pattern} with the point where pix_in is captured
  if (PIPE == 1) begin : g_pat_direct
    assign w_pat_tap = {test_mode, w_pat_raw};
  end else begin : g_pat_delay
    logic [1:0] r_pat [PIPE-1];

    // Pattern delay; one stage shorter than the timing chain
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < PIPE-1; i++) begin
          r_pat[i] <= 2'b00;
        end
      end else if (pix_en) begin
        r_pat[0] <= {test_mode, w_pat_raw};
        for (int i = 1; i < PIPE-1; i++) begin
          r_pat[i] <= r_pat[i-1];
        end
      end
    end

    assign w_pat_tap = r_pat[PIPE-2];
  end

  assign w_pix_sel = w_pat_tap[1] ? {COLOR_W{w_pat_tap[0]}} : pix_in;
`else
  assign w_pix_sel = pix_in;
`endif

  // Pixel capture: loads on the same enabled edge that moves a request into de,
  // so pix_in is taken on the PIPE-th enabled edge after its coordinate issued
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix <= '0;
    end else if (pix_en) begin
      r_pix <= w_pix_sel;
    end
  end

  assign pix_out = de ? r_pix : '0;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 400: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 12 / 2 / 35: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter HS_POL / VS_POL, defaults 0 / 1: asserted sync level (0 = active-low).
REQ-006 Parameter COLOR_W, default 3: pixel data width.
REQ-007 Parameter PIPE, default 2, range 1..8: cycles from coordinate issue to pix_in valid.
REQ-008 Derived widths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; X_W = clog2(H_TOTAL); Y_W = clog2(V_TOTAL).
REQ-009 Port clock, in, 1: sole clock; all logic on its rising edge.
REQ-010 Port reset, in, 1: synchronous, active-high.
REQ-011 Port pix_en, in, 1: pixel-rate enable; all state advances only when it is 1.
REQ-012 Port x / y, out, X_W / Y_W: current raster coordinates, undelayed.
REQ-013 Port req, out, 1: x,y lies inside the active area, undelayed.
REQ-014 Port line_start / frame_start, out, 1: one-enabled-cycle pulses at x==0 and at x==0&&y==0, undelayed.
REQ-015 Port pix_in, in, COLOR_W: external pixel, sampled PIPE enabled cycles after its req.
REQ-016 Port hsync / vsync / de / pix_out, out, 1/1/1/COLOR_W: timing and pixel outputs, delayed PIPE and mutually aligned.
REQ-017 Port frame_cnt, out, 16: completed-frame counter.

Function
REQ-018 x increments on each enabled cycle; it wraps H_TOTAL-1 -> 0, and on that wrap y increments; y wraps V_TOTAL-1 -> 0.
REQ-019 req = (x < H_ACTIVE) && (y < V_ACTIVE).
REQ-020 Raw hsync is asserted (HS_POL level) for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; raw vsync uses the same rule on y with the V_* parameters.
REQ-021 Raw hsync, vsync and req are delayed exactly PIPE enabled cycles to give hsync, vsync and de.
REQ-022 pix_out = pix_in when the delayed de is 1, else 0; registered in the same stage as de.
REQ-023 frame_cnt increments on the enabled cycle where y wraps to 0; it wraps 0xFFFF -> 0.
REQ-024 pix_en == 0: every register holds, including the delay line; pulses do not repeat.
REQ-025 Simultaneous x wrap and y wrap in one cycle: x=0, y=0, frame_start=1 and frame_cnt increments, all in that cycle.

Reset
REQ-026 On reset: x=0, y=0, frame_cnt=0, delay line flushed to deasserted sync levels, de=0, pix_out=0, line_start=0, frame_start=0.
REQ-027 First enabled cycle after reset deassertion: frame_start=1 with x=0, y=0.
REQ-028 Reset mid-frame takes priority over pix_en; no partial line or sync pulse is emitted afterwards.

Configuration
REQ-029 Macro VGA_TEST_PATTERN_EN; when defined, input port test_mode (1 bit) exists.
REQ-030 With the macro defined and test_mode=1: pix_out = {COLOR_W{((x+s)[4] ^ (y+(s>>2))[4])}} gated by de, where s = frame_cnt[9:0]; this is aligned through the same PIPE delay; pix_in is ignored.
REQ-031 Without the macro: test_mode and all pattern logic are absent, and pix_out follows REQ-022 only.

Structure
REQ-032 Package vga_timing_pkg holds the default timing constants (640x400 set) and the sync-polarity constants.
REQ-033 The delay line is sub-module vga_delay_line (parameters WIDTH, DEPTH, RESET_VAL; enable-gated shift register), instantiated once for {hsync, vsync, req}.
REQ-034 The pattern-generator logic is local and compiled under the macro.

Verification
REQ-035 Defaults, pix_en=1, reset release -> frame_start at cycle 0; next frame_start 800*449=359200 cycles later; frame_cnt=1.
REQ-036 Raw x=656..751 -> hsync=0 for exactly 96 enabled cycles, starting at x=656+PIPE; vsync=1 only for lines 412-413.
REQ-037 pix_in=x[2:0] driven PIPE=2 late -> pix_out equals the expected value in every active pixel and is 0 when de=0.
REQ-038 pix_en toggling 1,0,1,0 -> coordinates advance once every 2 clocks; a full frame takes 718400 clocks.
REQ-039 Reset asserted at x=700, y=200 -> the next cycle shows x=0, y=0, de=0, pix_out=0, sync at its inactive level.
REQ-040 Macro defined, test_mode=1, frame_cnt=16 -> at pixel (0,0), pix_out = 3'b111 (s=16: bit4 of 16 ^ bit4 of 4 = 1).
